// File: rtl/forwarding_scoreboard_if.sv
// Handshake bundle between the ID stage and the forwarding scoreboard.
// The master side (ID/pipeline control) drives the instruction fields and
// the advance/flush controls; the slave side (scoreboard) returns the EX
// operand selects, the load-use stall and the stall counter.
interface forwarding_scoreboard_if #(
   parameter int REG_AW     = 5,
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = 16
);
   localparam int SELW = $clog2(NUM_STAGES + 1);

   logic              adv;
   logic              flush;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_is_load;
   logic [SELW-1:0]   fwd_sel_a;
   logic [SELW-1:0]   fwd_sel_b;
   logic              stall;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output adv, flush, id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load,
      input  fwd_sel_a, fwd_sel_b, stall, stall_count
   );

   modport slave (
      input  adv, flush, id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load,
      output fwd_sel_a, fwd_sel_b, stall, stall_count
   );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: a NUM_STAGES-deep shift register of in-flight
// register writes that follows the pipeline after ID. Each operand forwards
// from the youngest matching stage; a match on a load that has not yet
// reached LOAD_READY raises a load-use stall instead. Stall cycles that
// actually advance the pipeline are counted with saturation.
module forwarding_scoreboard #(
   parameter int REG_AW     = 5,
   parameter int NUM_STAGES = 3,
   parameter int LOAD_READY = 2,
   parameter int CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   forwarding_scoreboard_if.slave bus
);
   localparam int SELW = $clog2(NUM_STAGES + 1);

   // Stage k lives at bit/element k; stage 1 is EX.
   logic [NUM_STAGES:1]             valid_q, valid_d;
   logic [NUM_STAGES:1][REG_AW-1:0] rd_q, rd_d;
   logic [NUM_STAGES:1]             load_q, load_d;
   logic [CNT_W-1:0]                stall_count_q, stall_count_d;

   logic [SELW-1:0] sel_a, sel_b;
   logic            stall_a, stall_b;
   logic            stall;

   // Youngest-match lookup for one operand; returns {stall_x, sel}.
   // An older match behind a not-yet-ready load is deliberately ignored:
   // its data is stale relative to the load.
   function automatic logic [SELW:0] lookup(input logic [REG_AW-1:0] rs);
      logic [SELW-1:0] m;
      logic            m_load;
      logic            st;
      m      = '0;
      m_load = 1'b0;
      st     = 1'b0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (valid_q[k] && (rd_q[k] == rs)) begin
            m      = SELW'(k);
            m_load = load_q[k];
         end
      end
      if (rs == '0) begin
         m      = '0;
         m_load = 1'b0;
      end
      if ((m != '0) && m_load && (int'(m) < LOAD_READY)) begin
         st = 1'b1;
         m  = '0;
      end
      return {st, m};
   endfunction

   // Operand selects and the combined load-use stall.
   always_comb begin
      {stall_a, sel_a} = lookup(bus.id_rs1);
      {stall_b, sel_b} = lookup(bus.id_rs2);
      stall = bus.id_valid & ~bus.flush & (stall_a | stall_b);
   end

   // Next entries: hold on freeze, bubble on flush/stall, else capture ID.
   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      load_d  = load_q;
      if (bus.adv) begin
         for (int k = NUM_STAGES; k >= 2; k--) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
            load_d[k]  = load_q[k-1];
         end
         if (bus.flush || stall) begin
            valid_d[1] = 1'b0;
         end else begin
            valid_d[1] = bus.id_valid & bus.id_regwrite & (bus.id_rd != '0);
         end
         rd_d[1]   = bus.id_rd;
         load_d[1] = bus.id_is_load;
      end
   end

   // Saturating count of stall cycles that actually advance.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && bus.adv && !(&stall_count_q)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   // State registers; reset empties the scoreboard and clears the counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q       <= '0;
         rd_q          <= '0;
         load_q        <= '0;
         stall_count_q <= '0;
      end else begin
         valid_q       <= valid_d;
         rd_q          <= rd_d;
         load_q        <= load_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.fwd_sel_a   = sel_a;
   assign bus.fwd_sel_b   = sel_b;
   assign bus.stall       = stall;
   assign bus.stall_count = stall_count_q;
endmodule
